// File: rtl/latency_interconnect_if.sv
// Master-side bus of the latency interconnect: request/handshake, read response and fault status.
interface latency_interconnect_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  req_m;
    logic                  we_m;
    logic [ADDR_WIDTH-1:0] addr_m;
    logic [DATA_WIDTH-1:0] wd_m;
    logic                  stall_m;
    logic                  rvalid_m;
    logic [DATA_WIDTH-1:0] rd_m;
    logic                  fault_m;
    logic [ADDR_WIDTH-1:0] fault_addr;
    logic [7:0]            fault_cnt;

    modport master (
        output req_m, we_m, addr_m, wd_m,
        input  stall_m, rvalid_m, rd_m, fault_m, fault_addr, fault_cnt
    );

    modport slave (
        input  req_m, we_m, addr_m, wd_m,
        output stall_m, rvalid_m, rd_m, fault_m, fault_addr, fault_cnt
    );
endinterface

// File: rtl/latency_interconnect.sv
// Single-master, N-slave interconnect with per-region read latency, master stall
// and unmapped-access fault capture.
module latency_interconnect #(
    parameter int                          REGIONS     = 5,
    parameter int                          DATA_WIDTH  = 32,
    parameter int                          ADDR_WIDTH  = 32,
    parameter logic [REGIONS*ADDR_WIDTH-1:0] REGION_BASE = '0,
    parameter logic [REGIONS*ADDR_WIDTH-1:0] REGION_END  = '0,
    parameter logic [REGIONS*2-1:0]        REGION_LAT  = {REGIONS{2'd1}}
) (
    input  logic                          clk,
    input  logic                          reset,
    latency_interconnect_if.slave         bus,
    output logic [REGIONS-1:0]            we_s,
    output logic [REGIONS*ADDR_WIDTH-1:0] addr_s,
    output logic [REGIONS*DATA_WIDTH-1:0] wd_s,
    input  logic [REGIONS*DATA_WIDTH-1:0] rd_s
);
    localparam int SEL_W = (REGIONS > 1) ? $clog2(REGIONS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t                state;
    logic                  stall;
    logic                  rvalid;
    logic                  fault;
    logic [ADDR_WIDTH-1:0] fault_addr;
    logic [7:0]            fault_cnt;
    logic [1:0]            cnt;
    logic [SEL_W-1:0]      sel;
    logic [ADDR_WIDTH-1:0] addr_q;

    logic                  hit_any;
    logic [SEL_W-1:0]      hit_sel;
    logic [1:0]            lat_raw;
    logic [1:0]            lat_cnt;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] live_addr;

    // Lowest matching index wins when regions overlap.
    always_comb begin
        hit_any = 1'b0;
        hit_sel = '0;
        for (int unsigned i = 0; i < REGIONS; i++) begin
            if (!hit_any &&
                bus.addr_m >= REGION_BASE[i*ADDR_WIDTH +: ADDR_WIDTH] &&
                bus.addr_m <  REGION_END[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                hit_any = 1'b1;
                hit_sel = SEL_W'(i);
            end
        end
    end

    always_comb begin
        lat_raw = REGION_LAT[hit_sel*2 +: 2];
        lat_cnt = (lat_raw == 2'd0) ? 2'd0 : lat_raw - 2'd1;
        accept  = bus.req_m && !stall && !reset;
    end

    always_comb begin
        we_s = '0;
        if (accept && bus.we_m && hit_any) begin
            we_s[hit_sel] = 1'b1;
        end
    end

    // Slaves see the captured address for the whole pipelined read.
    always_comb begin
        live_addr = (state == WAIT) ? addr_q : bus.addr_m;
        addr_s    = '0;
        for (int unsigned i = 0; i < REGIONS; i++) begin
            addr_s[i*ADDR_WIDTH +: ADDR_WIDTH] = live_addr - REGION_BASE[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    always_comb begin
        wd_s = {REGIONS{bus.wd_m}};
    end

    always_comb begin
        bus.stall_m    = stall;
        bus.rvalid_m   = rvalid;
        bus.fault_m    = fault;
        bus.fault_addr = fault_addr;
        bus.fault_cnt  = fault_cnt;
        bus.rd_m       = (rvalid && !fault) ? rd_s[sel*DATA_WIDTH +: DATA_WIDTH] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            stall      <= 1'b0;
            rvalid     <= 1'b0;
            fault      <= 1'b0;
            fault_addr <= '0;
            fault_cnt  <= '0;
            cnt        <= '0;
            sel        <= '0;
            addr_q     <= '0;
        end else begin
            rvalid <= 1'b0;
            fault  <= 1'b0;
            case (state)
                WAIT: begin
                    cnt <= cnt - 2'd1;
                    if (cnt == 2'd1) begin
                        state  <= IDLE;
                        stall  <= 1'b0;
                        rvalid <= 1'b1;
                    end
                end
                default: begin
                    // FAULT never stalls, so it accepts exactly like IDLE.
                    state <= IDLE;
                    if (accept) begin
                        if (!hit_any) begin
                            state      <= FAULT;
                            fault      <= 1'b1;
                            rvalid     <= !bus.we_m;
                            fault_addr <= bus.addr_m;
                            if (fault_cnt != 8'hFF) begin
                                fault_cnt <= fault_cnt + 8'd1;
                            end
                        end else if (!bus.we_m) begin
                            sel    <= hit_sel;
                            addr_q <= bus.addr_m;
                            cnt    <= lat_cnt;
                            if (lat_cnt == 2'd0) begin
                                rvalid <= 1'b1;
                            end else begin
                                state <= WAIT;
                                stall <= 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_latency_interconnect.sv
// Directed self-checking bench for latency_interconnect.
module tb_latency_interconnect;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int R  = 5;
    localparam logic [R*AW-1:0] BASE = {32'h4000, 32'h3000, 32'h2000, 32'h1000, 32'h0000};
    localparam logic [R*AW-1:0] ENDA = {32'h5000, 32'h4000, 32'h3000, 32'h2000, 32'h1000};
    localparam logic [R*2-1:0]  LAT  = {2'd1, 2'd2, 2'd0, 2'd3, 2'd1};
    localparam logic [2*AW-1:0] BASE2 = {32'h0000, 32'h0000};
    localparam logic [2*AW-1:0] END2  = {32'h2000, 32'h1000};
    localparam logic [31:0] RD0 = 32'h0F0F_0F0F;
    localparam logic [31:0] RD1 = 32'h1111_1111;
    localparam logic [31:0] RD2 = 32'h2222_2222;
    localparam logic [31:0] RD3 = 32'h3333_3333;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    latency_interconnect_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    latency_interconnect_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus2 ();

    logic [R-1:0]    we_s;
    logic [R*AW-1:0] addr_s;
    logic [R*DW-1:0] wd_s;
    logic [R*DW-1:0] rd_s;
    logic [1:0]      we_s2;
    logic [2*AW-1:0] addr_s2;
    logic [2*DW-1:0] wd_s2;
    logic [2*DW-1:0] rd_s2;

    latency_interconnect #(
        .REGIONS(R), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .REGION_BASE(BASE), .REGION_END(ENDA), .REGION_LAT(LAT)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .we_s(we_s), .addr_s(addr_s), .wd_s(wd_s), .rd_s(rd_s)
    );

    latency_interconnect #(
        .REGIONS(2), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .REGION_BASE(BASE2), .REGION_END(END2), .REGION_LAT({2'd1, 2'd1})
    ) dut2 (
        .clk(clk), .reset(reset), .bus(bus2),
        .we_s(we_s2), .addr_s(addr_s2), .wd_s(wd_s2), .rd_s(rd_s2)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        n_cmp++; if (bus.stall_m !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%h exp=0", bus.stall_m); end
        n_cmp++; if (bus.rvalid_m !== 1'b0) begin n_err++; $display("FAIL reset_rvalid got=%h exp=0", bus.rvalid_m); end
        n_cmp++; if (bus.rd_m !== 32'h0) begin n_err++; $display("FAIL reset_rd got=%h exp=0", bus.rd_m); end
        n_cmp++; if (bus.fault_m !== 1'b0) begin n_err++; $display("FAIL reset_fault got=%h exp=0", bus.fault_m); end
        n_cmp++; if (bus.fault_addr !== 32'h0) begin n_err++; $display("FAIL reset_fault_addr got=%h exp=0", bus.fault_addr); end
        n_cmp++; if (bus.fault_cnt !== 8'h0) begin n_err++; $display("FAIL reset_fault_cnt got=%h exp=0", bus.fault_cnt); end
        n_cmp++; if (we_s !== 5'b0) begin n_err++; $display("FAIL reset_we_s got=%b exp=00000", we_s); end
    endtask

    task automatic test_read_l1();
        tick();
        bus.req_m = 1'b1; bus.we_m = 1'b0; bus.addr_m = 32'h0000_0004;
        #1;
        n_cmp++; if (addr_s[0*AW +: AW] !== 32'h4) begin n_err++; $display("FAIL l1_addr_s0 got=%h exp=4", addr_s[0*AW +: AW]); end
        n_cmp++; if (addr_s[1*AW +: AW] !== 32'hFFFF_F004) begin n_err++; $display("FAIL l1_addr_s1_wrap got=%h exp=fffff004", addr_s[1*AW +: AW]); end
        n_cmp++; if (bus.stall_m !== 1'b0) begin n_err++; $display("FAIL l1_stall_c0 got=%h exp=0", bus.stall_m); end
        n_cmp++; if (we_s !== 5'b0) begin n_err++; $display("FAIL l1_we_s got=%b exp=00000", we_s); end
        tick();
        bus.req_m = 1'b0;
        #1;
        n_cmp++; if (bus.rvalid_m !== 1'b1) begin n_err++; $display("FAIL l1_rvalid_c1 got=%h exp=1", bus.rvalid_m); end
        n_cmp++; if (bus.rd_m !== RD0) begin n_err++; $display("FAIL l1_rd_c1 got=%h exp=%h", bus.rd_m, RD0); end
        n_cmp++; if (bus.stall_m !== 1'b0) begin n_err++; $display("FAIL l1_stall_c1 got=%h exp=0", bus.stall_m); end
        n_cmp++; if (bus.fault_m !== 1'b0) begin n_err++; $display("FAIL l1_fault_c1 got=%h exp=0", bus.fault_m); end
        tick();
        n_cmp++; if (bus.rvalid_m !== 1'b0) begin n_err++; $display("FAIL l1_rvalid_c2 got=%h exp=0", bus.rvalid_m); end
        n_cmp++; if (bus.rd_m !== 32'h0) begin n_err++; $display("FAIL l1_rd_c2 got=%h exp=0", bus.rd_m); end
    endtask

    task automatic test_read_l3();
        tick();
        bus.req_m = 1'b1; bus.we_m = 1'b0; bus.addr_m = 32'h0000_1008;
        #1;
        n_cmp++; if (addr_s[1*AW +: AW] !== 32'h8) begin n_err++; $display("FAIL l3_addr_c0 got=%h exp=8", addr_s[1*AW +: AW]); end
        n_cmp++; if (bus.stall_m !== 1'b0) begin n_err++; $display("FAIL l3_stall_c0 got=%h exp=0", bus.stall_m); end
        tick();
        // A write presented while stalled must not be forwarded.
        bus.req_m = 1'b1; bus.we_m = 1'b1; bus.addr_m = 32'h0000_0010;
        #1;
        n_cmp++; if (bus.stall_m !== 1'b1) begin n_err++; $display("FAIL l3_stall_c1 got=%h exp=1", bus.stall_m); end
        n_cmp++; if (addr_s[1*AW +: AW] !== 32'h8) begin n_err++; $display("FAIL l3_addr_c1 got=%h exp=8", addr_s[1*AW +: AW]); end
        n_cmp++; if (we_s !== 5'b0) begin n_err++; $display("FAIL l3_stalled_write got=%b exp=00000", we_s); end
        n_cmp++; if (bus.rvalid_m !== 1'b0) begin n_err++; $display("FAIL l3_rvalid_c1 got=%h exp=0", bus.rvalid_m); end
        tick();
        bus.req_m = 1'b0; bus.we_m = 1'b0;
        #1;
        n_cmp++; if (bus.stall_m !== 1'b1) begin n_err++; $display("FAIL l3_stall_c2 got=%h exp=1", bus.stall_m); end
        n_cmp++; if (addr_s[1*AW +: AW] !== 32'h8) begin n_err++; $display("FAIL l3_addr_c2 got=%h exp=8", addr_s[1*AW +: AW]); end
        n_cmp++; if (bus.rvalid_m !== 1'b0) begin n_err++; $display("FAIL l3_rvalid_c2 got=%h exp=0", bus.rvalid_m); end
        tick();
        bus.req_m = 1'b1; bus.we_m = 1'b0; bus.addr_m = 32'h0000_0004;
        #1;
        n_cmp++; if (bus.stall_m !== 1'b0) begin n_err++; $display("FAIL l3_stall_c3 got=%h exp=0", bus.stall_m); end
        n_cmp++; if (bus.rvalid_m !== 1'b1) begin n_err++; $display("FAIL l3_rvalid_c3 got=%h exp=1", bus.rvalid_m); end
        n_cmp++; if (bus.rd_m !== RD1) begin n_err++; $display("FAIL l3_rd_c3 got=%h exp=%h", bus.rd_m, RD1); end
        tick();
        bus.req_m = 1'b0;
        #1;
        n_cmp++; if (bus.rvalid_m !== 1'b1) begin n_err++; $display("FAIL l3_b2b_rvalid_c4 got=%h exp=1", bus.rvalid_m); end
        n_cmp++; if (bus.rd_m !== RD0) begin n_err++; $display("FAIL l3_b2b_rd_c4 got=%h exp=%h", bus.rd_m, RD0); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3];
        addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8;
        tick();
        bus.req_m = 1'b1; bus.we_m = 1'b0; bus.addr_m = addrs[0];
        #1;
        n_cmp++; if (bus.stall_m !== 1'b0) begin n_err++; $display("FAIL b2b_stall_c0 got=%h exp=0", bus.stall_m); end
        for (int k = 1; k <= 3; k++) begin
            tick();
            if (k < 3) bus.addr_m = addrs[k];
            else bus.req_m = 1'b0;
            #1;
            n_cmp++; if (bus.rvalid_m !== 1'b1) begin n_err++; $display("FAIL b2b_rvalid_c%0d got=%h exp=1", k, bus.rvalid_m); end
            n_cmp++; if (bus.rd_m !== RD0) begin n_err++; $display("FAIL b2b_rd_c%0d got=%h exp=%h", k, bus.rd_m, RD0); end
            n_cmp++; if (bus.stall_m !== 1'b0) begin n_err++; $display("FAIL b2b_stall_c%0d got=%h exp=0", k, bus.stall_m); end
        end
        tick();
        n_cmp++; if (bus.rvalid_m !== 1'b0) begin n_err++; $display("FAIL b2b_rvalid_end got=%h exp=0", bus.rvalid_m); end
    endtask

    task automatic test_latency_variants();
        tick();
        bus.req_m = 1'b1; bus.we_m = 1'b0; bus.addr_m = 32'h0000_2000;
        tick();
        bus.req_m = 1'b0;
        #1;
        n_cmp++; if (bus.rvalid_m !== 1'b1) begin n_err++; $display("FAIL lat0_rvalid_c1 got=%h exp=1", bus.rvalid_m); end
        n_cmp++; if (bus.rd_m !== RD2) begin n_err++; $display("FAIL lat0_rd_c1 got=%h exp=%h", bus.rd_m, RD2); end
        tick();
        bus.req_m = 1'b1; bus.addr_m = 32'h0000_3000;
        tick();
        bus.req_m = 1'b0;
        #1;
        n_cmp++; if (bus.stall_m !== 1'b1) begin n_err++; $display("FAIL lat2_stall_c1 got=%h exp=1", bus.stall_m); end
        n_cmp++; if (bus.rvalid_m !== 1'b0) begin n_err++; $display("FAIL lat2_rvalid_c1 got=%h exp=0", bus.rvalid_m); end
        tick();
        n_cmp++; if (bus.rvalid_m !== 1'b1) begin n_err++; $display("FAIL lat2_rvalid_c2 got=%h exp=1", bus.rvalid_m); end
        n_cmp++; if (bus.rd_m !== RD3) begin n_err++; $display("FAIL lat2_rd_c2 got=%h exp=%h", bus.rd_m, RD3); end
        n_cmp++; if (bus.stall_m !== 1'b0) begin n_err++; $display("FAIL lat2_stall_c2 got=%h exp=0", bus.stall_m); end
    endtask

    task automatic test_write();
        tick();
        bus.req_m = 1'b1; bus.we_m = 1'b1; bus.addr_m = 32'h0000_1010; bus.wd_m = 32'hDEAD_BEEF;
        #1;
        n_cmp++; if (we_s !== 5'b00010) begin n_err++; $display("FAIL wr_we_s_c0 got=%b exp=00010", we_s); end
        n_cmp++; if (addr_s[1*AW +: AW] !== 32'h10) begin n_err++; $display("FAIL wr_addr_s1 got=%h exp=10", addr_s[1*AW +: AW]); end
        n_cmp++; if (wd_s[0*DW +: DW] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wr_wd_s0 got=%h exp=deadbeef", wd_s[0*DW +: DW]); end
        n_cmp++; if (wd_s[4*DW +: DW] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wr_wd_s4 got=%h exp=deadbeef", wd_s[4*DW +: DW]); end
        tick();
        bus.req_m = 1'b0;
        #1;
        n_cmp++; if (we_s !== 5'b0) begin n_err++; $display("FAIL wr_we_s_c1 got=%b exp=00000", we_s); end
        n_cmp++; if (bus.rvalid_m !== 1'b0) begin n_err++; $display("FAIL wr_rvalid_c1 got=%h exp=0", bus.rvalid_m); end
        n_cmp++; if (bus.stall_m !== 1'b0) begin n_err++; $display("FAIL wr_stall_c1 got=%h exp=0", bus.stall_m); end
        tick();
        n_cmp++; if (bus.rvalid_m !== 1'b0) begin n_err++; $display("FAIL wr_rvalid_c2 got=%h exp=0", bus.rvalid_m); end
    endtask

    task automatic test_fault();
        tick();
        bus.req_m = 1'b1; bus.we_m = 1'b0; bus.addr_m = 32'h8000_0000;
        #1;
        n_cmp++; if (we_s !== 5'b0) begin n_err++; $display("FAIL flt_we_s_c0 got=%b exp=00000", we_s); end
        tick();
        bus.req_m = 1'b0;
        #1;
        n_cmp++; if (bus.fault_m !== 1'b1) begin n_err++; $display("FAIL flt_fault_c1 got=%h exp=1", bus.fault_m); end
        n_cmp++; if (bus.rvalid_m !== 1'b1) begin n_err++; $display("FAIL flt_rvalid_c1 got=%h exp=1", bus.rvalid_m); end
        n_cmp++; if (bus.rd_m !== 32'h0) begin n_err++; $display("FAIL flt_rd_c1 got=%h exp=0", bus.rd_m); end
        n_cmp++; if (bus.fault_addr !== 32'h8000_0000) begin n_err++; $display("FAIL flt_addr got=%h exp=80000000", bus.fault_addr); end
        n_cmp++; if (bus.fault_cnt !== 8'd1) begin n_err++; $display("FAIL flt_cnt got=%0d exp=1", bus.fault_cnt); end
        n_cmp++; if (bus.stall_m !== 1'b0) begin n_err++; $display("FAIL flt_stall_c1 got=%h exp=0", bus.stall_m); end
        tick();
        n_cmp++; if (bus.fault_m !== 1'b0) begin n_err++; $display("FAIL flt_fault_c2 got=%h exp=0", bus.fault_m); end
        n_cmp++; if (bus.rvalid_m !== 1'b0) begin n_err++; $display("FAIL flt_rvalid_c2 got=%h exp=0", bus.rvalid_m); end
    endtask

    task automatic test_fault_saturate();
        logic we_seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            bus.req_m = 1'b1; bus.we_m = 1'b1; bus.addr_m = 32'h9000_0000 + 32'(i * 4);
            #1;
            if (we_s !== 5'b0) we_seen = 1'b1;
        end
        tick();
        bus.req_m = 1'b0; bus.we_m = 1'b0;
        #1;
        n_cmp++; if (we_seen !== 1'b0) begin n_err++; $display("FAIL sat_no_we_s got=%b exp=0", we_seen); end
        n_cmp++; if (bus.fault_cnt !== 8'd255) begin n_err++; $display("FAIL sat_cnt got=%0d exp=255", bus.fault_cnt); end
        n_cmp++; if (bus.fault_addr !== 32'h9000_04AC) begin n_err++; $display("FAIL sat_addr got=%h exp=900004ac", bus.fault_addr); end
        n_cmp++; if (bus.fault_m !== 1'b1) begin n_err++; $display("FAIL sat_fault_last got=%h exp=1", bus.fault_m); end
        n_cmp++; if (bus.rvalid_m !== 1'b0) begin n_err++; $display("FAIL sat_wr_rvalid got=%h exp=0", bus.rvalid_m); end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        tick();
        bus.req_m = 1'b1; bus.we_m = 1'b0; bus.addr_m = 32'h0000_1000;
        tick();
        bus.req_m = 1'b0; reset = 1'b1;
        #1;
        n_cmp++; if (bus.stall_m !== 1'b1) begin n_err++; $display("FAIL rmw_stall_c1 got=%h exp=1", bus.stall_m); end
        tick();
        reset = 1'b0;
        #1;
        n_cmp++; if (bus.stall_m !== 1'b0) begin n_err++; $display("FAIL rmw_stall_c2 got=%h exp=0", bus.stall_m); end
        n_cmp++; if (bus.rvalid_m !== 1'b0) begin n_err++; $display("FAIL rmw_rvalid_c2 got=%h exp=0", bus.rvalid_m); end
        n_cmp++; if (bus.fault_cnt !== 8'd0) begin n_err++; $display("FAIL rmw_fault_cnt got=%0d exp=0", bus.fault_cnt); end
        n_cmp++; if (bus.fault_addr !== 32'h0) begin n_err++; $display("FAIL rmw_fault_addr got=%h exp=0", bus.fault_addr); end
        n_cmp++; if (bus.fault_m !== 1'b0) begin n_err++; $display("FAIL rmw_fault got=%h exp=0", bus.fault_m); end
        tick();
        n_cmp++; if (bus.rvalid_m !== 1'b0) begin n_err++; $display("FAIL rmw_rvalid_c3 got=%h exp=0", bus.rvalid_m); end
        n_cmp++; if (bus.rd_m !== 32'h0) begin n_err++; $display("FAIL rmw_rd_c3 got=%h exp=0", bus.rd_m); end
    endtask

    task automatic test_reset_with_req();
        tick();
        reset = 1'b1; bus.req_m = 1'b1; bus.we_m = 1'b1; bus.addr_m = 32'h0000_0010;
        #1;
        n_cmp++; if (we_s !== 5'b0) begin n_err++; $display("FAIL rwr_we_s got=%b exp=00000", we_s); end
        tick();
        bus.we_m = 1'b0; bus.addr_m = 32'h0000_0004;
        tick();
        reset = 1'b0; bus.req_m = 1'b0;
        #1;
        n_cmp++; if (bus.rvalid_m !== 1'b0) begin n_err++; $display("FAIL rwr_rvalid got=%h exp=0", bus.rvalid_m); end
    endtask

    task automatic test_overlap();
        tick();
        bus2.req_m = 1'b1; bus2.we_m = 1'b1; bus2.addr_m = 32'h0000_0800;
        #1;
        n_cmp++; if (we_s2 !== 2'b01) begin n_err++; $display("FAIL ovl_we_s_0800 got=%b exp=01", we_s2); end
        tick();
        bus2.addr_m = 32'h0000_1800;
        #1;
        n_cmp++; if (we_s2 !== 2'b10) begin n_err++; $display("FAIL ovl_we_s_1800 got=%b exp=10", we_s2); end
        tick();
        bus2.req_m = 1'b0;
        #1;
        n_cmp++; if (we_s2 !== 2'b00) begin n_err++; $display("FAIL ovl_we_s_idle got=%b exp=00", we_s2); end
    endtask

    initial begin
        reset = 1'b1;
        bus.req_m = 1'b0; bus.we_m = 1'b0; bus.addr_m = '0; bus.wd_m = '0;
        bus2.req_m = 1'b0; bus2.we_m = 1'b0; bus2.addr_m = '0; bus2.wd_m = '0;
        rd_s = {32'h4444_4444, RD3, RD2, RD1, RD0};
        rd_s2 = {32'hBBBB_0001, 32'hAAAA_0000};
        test_reset();
        test_read_l1();
        test_read_l3();
        test_back_to_back();
        test_latency_variants();
        test_write();
        test_fault();
        test_fault_saturate();
        test_reset_mid_wait();
        test_reset_with_req();
        test_overlap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
